// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared master indices, arbiter state type and burst counter sizing
package dmem_arb_pkg;
  localparam logic MST_CPU = 1'b0;
  localparam logic MST_DBG = 1'b1;
  typedef enum logic {ARB, LOCKED} state_t;
  function automatic int burst_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin grant; a forced debug grant overrides the pointer
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       force_dbg_i,
  output logic [1:0] gnt_o
);
  logic ptr_q, ptr_d;
  always_comb begin
    gnt_o[MST_CPU] = ~force_dbg_i & req_i[MST_CPU] & (~req_i[MST_DBG] | (ptr_q == MST_CPU));
    gnt_o[MST_DBG] = req_i[MST_DBG] & ~gnt_o[MST_CPU];
    ptr_d = gnt_o[MST_CPU] ? MST_DBG : gnt_o[MST_DBG] ? MST_CPU : ptr_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr_q <= MST_CPU;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one synchronous data memory between the CPU LSU and the debug port,
// with a bounded debug lock and 1-cycle read response routing
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_wstrb,
  output logic                cpu_gnt,
  output logic                cpu_rvalid,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_stall,
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  input  logic [DATA_W/8-1:0] dbg_wstrb,
  input  logic                dbg_lock,
  output logic                dbg_gnt,
  output logic                dbg_rvalid,
  output logic [DATA_W-1:0]   dbg_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int CW = burst_cnt_w(MAX_BURST);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic lock_hold, rv_q, own_q;
  logic [DATA_W-1:0] cpu_rd_q, dbg_rd_q;
  logic [1:0] gnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ARB;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  // Every locked-mode debug grant keeps the lock; the counter only ages while the CPU waits
  always_comb begin
    state_d = (dbg_gnt & dbg_lock) ? LOCKED : ARB;
    cnt_d = (dbg_gnt & dbg_lock) ? cnt_q + CW'(cpu_req) : '0;
  end
  always_comb
    lock_hold = (state_q == LOCKED) & dbg_req & dbg_lock & ~(cpu_req & (cnt_q == CW'(MAX_BURST)));
  rr_arb2 u_rr (
    .clk(clk),
    .rst(reset),
    .req_i({dbg_req, cpu_req}),
    .force_dbg_i(lock_hold),
    .gnt_o(gnt)
  );
  assign cpu_gnt = gnt[MST_CPU];
  assign dbg_gnt = gnt[MST_DBG];
  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign mem_en = cpu_gnt | dbg_gnt;
  assign mem_we = dbg_gnt ? dbg_we : cpu_gnt & cpu_we;
  assign mem_addr = dbg_gnt ? dbg_addr : cpu_addr;
  assign mem_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
  assign mem_wstrb = dbg_gnt ? dbg_wstrb : cpu_wstrb;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rv_q <= 1'b0;
      own_q <= MST_CPU;
      cpu_rd_q <= '0;
      dbg_rd_q <= '0;
    end else begin
      rv_q <= mem_en & ~mem_we;
      own_q <= dbg_gnt ? MST_DBG : MST_CPU;
      if (cpu_rvalid) cpu_rd_q <= mem_rdata;
      if (dbg_rvalid) dbg_rd_q <= mem_rdata;
    end
  assign cpu_rvalid = rv_q & (own_q == MST_CPU);
  assign dbg_rvalid = rv_q & (own_q == MST_DBG);
  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rd_q;
  assign dbg_rdata = dbg_rvalid ? mem_rdata : dbg_rd_q;
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Two-master arbiter that shares the single-port, synchronous data memory between the CPU load/store unit (master 0) and the debug/program-loader port (master 1). It lets memory be loaded and inspected at run time instead of only by preload, while the core keeps running. The arbiter grants at most one access per cycle, routes 1-cycle-latency read data back to the issuing master, and drives a stall to the CPU while the core is denied. A lock input lets the debug port hold the memory for bounded bursts.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data word width
MAX_BURST, 8, max consecutive locked debug grants while the CPU is waiting (range 1..255)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request, held until granted
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  byte address
cpu_wdata  in  DATA_W  write data
cpu_wstrb  in  DATA_W/8  byte enables
cpu_gnt  out  1  access issued this cycle
cpu_rvalid  out  1  read data valid
cpu_rdata  out  DATA_W  read data
cpu_stall  out  1  cpu_req & ~cpu_gnt (combinational)
dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_wstrb  in  as CPU  debug request bundle
dbg_lock  in  1  keep debug ownership for back-to-back grants
dbg_gnt, dbg_rvalid  out  1  as CPU
dbg_rdata  out  DATA_W  as CPU
mem_en  out  1  memory access strobe
mem_we  out  1  write enable
mem_addr  out  ADDR_W  address
mem_wdata  out  DATA_W  write data
mem_wstrb  out  DATA_W/8  byte enables
mem_rdata  in  DATA_W  read data, valid the cycle after mem_en & ~mem_we

Behaviour:
- Reset values: all gnt, rvalid, and mem_en outputs 0. rdata outputs 0. Priority pointer = CPU. Burst counter = 0. State = ARB.
- The grant path is combinational from req. mem_* mux the granted master's bundle. mem_en = cpu_gnt | dbg_gnt. gnt signals are mutually exclusive.
- A master's request bundle must stay stable while req=1 && gnt=0. The arbiter does not check this.
- State ARB, round-robin:
  - If exactly one master is requesting, grant it.
  - If both are requesting, grant the master the pointer favours.
  - After a grant, the pointer moves to the other master.
- State LOCKED is entered when the debug port is granted with dbg_lock=1.
  - In LOCKED, the debug port is granted every cycle it requests, regardless of the pointer.
  - The burst counter increments on each locked grant while cpu_req=1.
  - Exit to ARB, with the pointer set to CPU, when any of these holds: dbg_lock=0, dbg_req=0, or counter==MAX_BURST with cpu_req=1.
  - The counter clears on exit.
- Read response:
  - On a granted read, register owner and valid.
  - Next cycle, raise the owner's rvalid for 1 cycle and drive that owner's rdata = mem_rdata. The other master's rdata holds its last value.
  - Writes produce no rvalid.
- Back-to-back reads from either master are allowed at full throughput. Responses return in issue order, one per cycle.
- Response routing is independent of the current-cycle grant: a grant to master 1 in the same cycle that master 0's rvalid fires is legal.
- Reset mid-operation: any pending rvalid is discarded and the lock is dropped.
- cpu_stall = cpu_req & ~cpu_gnt. It is never asserted when cpu_req=0.

Decomposition:
- Package dmem_arb_pkg holds:
  - master-index constants MST_CPU=0, MST_DBG=1
  - the state enum {ARB, LOCKED}
  - the width of the burst counter, $clog2(MAX_BURST+1)
- One natural sub-module, rr_arb2: 2-way round-robin grant with pointer update.
- The lock FSM, response tracker and muxes stay in the top module.

Test Plan:
1. Reset, then cpu_req read at 0x10 with mem preloaded to 0xDEADBEEF -> cpu_gnt same cycle; cpu_rvalid=1 and cpu_rdata=0xDEADBEEF one cycle later; dbg_rvalid stays 0.
2. Both masters issue continuous reads -> grants alternate CPU, DBG, CPU, ...; cpu_stall=1 exactly on the DBG-granted cycles; each rvalid returns to its issuer.
3. dbg_lock=1 with 20 dbg writes while cpu_req is held -> 8 consecutive dbg_gnt, then 1 cpu_gnt, then debug regains the lock; no grant overlap.
4. dbg write 0x12345678 with wstrb=4'b0011 to 0x20, then CPU read of 0x20 -> mem_wstrb=4'b0011 on the write; CPU reads the merged word; no rvalid for the write.
5. Assert reset in the cycle after a granted dbg read -> dbg_rvalid stays 0, state returns to ARB, and the first post-reset contention grants the CPU.
6. dbg_lock=1 with cpu_req=0 for 30 cycles -> 30 consecutive dbg grants, burst counter stays 0, no forced release.
